mem_arbiter: RTL

- Parametrised N-channel arbiter that multiplexes cache-side memory requests onto the single memory-controller port of the core.
- Successor to the single ICache-to-memory path, so that ICache, DCache and future requesters share one memory controller.
- Uses the same rw_flag/addr/read_data/write_data/write_mask/busy/done handshake on both sides.
- Adds selectable round-robin or fixed-priority arbitration and one-outstanding-transaction sequencing.

---
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel arbiter that shares one memory-controller port
// between several cache-side requesters (ICache, DCache, ...).
//
// Only one transaction is in flight at a time. The sequence is
// IDLE -> WAIT -> DONE -> IDLE. A winner is selected either round-robin
// (RR_MODE=1) or by fixed priority with the lowest index winning (RR_MODE=0).
// All outputs are registered.
//
// Ports (channel i occupies slice [i*W +: W] of every flattened bus):
//   clk, rst        clock, synchronous active-high reset
//   ch_rw_flag      per-channel request: 0 idle, 1 read, 2 write, 3 reserved (idle)
//   ch_addr         per-channel address
//   ch_write_data   per-channel write data
//   ch_write_mask   per-channel byte mask
//   ch_read_data    per-channel returned read data (updated on read completion)
//   ch_busy         all ones while a transaction is being sequenced
//   ch_done         one-cycle completion pulse to the granted channel
//   mem_rw_flag     request to the memory controller
//   mem_addr        address to the memory controller
//   mem_write_data  write data to the memory controller
//   mem_write_mask  byte mask to the memory controller
//   mem_read_data   read data from the memory controller, valid with mem_done
//   mem_busy        controller busy (informational, not used for decisions)
//   mem_done        one-cycle completion from the memory controller
module mem_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MASK_W  = 4,
    parameter int FLAG_W  = 2,
    parameter int RR_MODE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH*FLAG_W-1:0]   ch_rw_flag,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_write_data,
    input  logic [NUM_CH*MASK_W-1:0]   ch_write_mask,
    output logic [NUM_CH*DATA_W-1:0]   ch_read_data,
    output logic [NUM_CH-1:0]          ch_busy,
    output logic [NUM_CH-1:0]          ch_done,
    output logic [FLAG_W-1:0]          mem_rw_flag,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_write_data,
    output logic [MASK_W-1:0]          mem_write_mask,
    input  logic [DATA_W-1:0]          mem_read_data,
    input  logic                       mem_busy,
    input  logic                       mem_done
);

    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [FLAG_W-1:0] FLAG_RD = FLAG_W'(1);
    localparam logic [FLAG_W-1:0] FLAG_WR = FLAG_W'(2);
    localparam logic [NUM_CH-1:0] CH_ONE  = NUM_CH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   winner;
    logic [NUM_CH-1:0] req;
    logic            any_req;
    logic            found;
    int              sel_idx;

    // The memory controller's busy flag carries no decision here.
    logic unused_mem_busy;
    assign unused_mem_busy = mem_busy;

    // Pointer that follows a grant, wrapping from NUM_CH-1 back to 0.
    function automatic logic [GW-1:0] ptr_after(input logic [GW-1:0] g);
        if (int'(g) >= NUM_CH - 1) begin
            return '0;
        end
        return g + GW'(1);
    endfunction

    // Only read and write count as requests; the reserved code is idle.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req[i] = (ch_rw_flag[i*FLAG_W +: FLAG_W] == FLAG_RD) ||
                     (ch_rw_flag[i*FLAG_W +: FLAG_W] == FLAG_WR);
        end
    end

    assign any_req = |req;

    // Winner search: upward from rr_ptr with wrap in round-robin mode,
    // upward from index 0 in fixed-priority mode.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        sel_idx = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (RR_MODE != 0) begin
                sel_idx = int'(rr_ptr) + k;
                if (sel_idx >= NUM_CH) begin
                    sel_idx = sel_idx - NUM_CH;
                end
            end else begin
                sel_idx = k;
            end
            if (!found && req[sel_idx]) begin
                winner = GW'(sel_idx);
                found  = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (any_req)  next_state = S_WAIT;
            S_WAIT: if (mem_done) next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Registered outputs. The request is latched once in IDLE and held
    // through WAIT, so channel-side changes during WAIT have no effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr         <= '0;
            grant          <= '0;
            mem_rw_flag    <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_write_mask <= '0;
            ch_read_data   <= '0;
            ch_busy        <= '0;
            ch_done        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant          <= winner;
                        mem_rw_flag    <= ch_rw_flag[int'(winner)*FLAG_W +: FLAG_W];
                        mem_addr       <= ch_addr[int'(winner)*ADDR_W +: ADDR_W];
                        mem_write_data <= ch_write_data[int'(winner)*DATA_W +: DATA_W];
                        mem_write_mask <= ch_write_mask[int'(winner)*MASK_W +: MASK_W];
                        ch_busy        <= '1;
                    end
                end
                S_WAIT: begin
                    if (mem_done) begin
                        // The latched flag tells reads from writes; writes
                        // leave the channel's read-data slice untouched.
                        if (mem_rw_flag == FLAG_RD) begin
                            ch_read_data[int'(grant)*DATA_W +: DATA_W] <= mem_read_data;
                        end
                        mem_rw_flag <= '0;
                        ch_done     <= CH_ONE << grant;
                    end
                end
                S_DONE: begin
                    ch_done <= '0;
                    ch_busy <= '0;
                    if (RR_MODE != 0) begin
                        rr_ptr <= ptr_after(grant);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
